// File: rtl/tele_pulse_decoder.sv
// Door-handle telegram receiver: measures pulse high-times, classifies them
// against nominal widths and reassembles 6-bit or 5-bit (NFC bypass) frames.
module tele_pulse_decoder #(
  parameter logic [15:0] TOL     = 16'd50,
  parameter logic [15:0] GAP_MAX = 16'd4000
) (
  input  logic        clk_out,
  input  logic        reset,
  input  logic        pulse_in,
  input  logic [15:0] ON_imp,
  input  logic [15:0] ON_low,
  input  logic [15:0] ON_high,
  input  logic [15:0] ON_stop,
  output logic [7:0]  tele,
  output logic        frame_valid,
  output logic [7:0]  frame_count,
  output logic        err_width,
  output logic        err_count,
  output logic        err_timeout,
  output logic        locked
);

  typedef enum logic {S_HUNT, S_DATA} state_e;
  typedef enum logic [2:0] {P_BAD, P_LOW, P_HIGH, P_STOP, P_IMP} pulse_e;

  logic        s1_q, s2_q, s3_q;
  logic [15:0] hi_cnt_q, hi_cnt_d;
  logic [15:0] lo_cnt_q, lo_cnt_d;
  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [5:0]  data_q;
  logic [7:0]  tele_q, frame_count_q;
  logic        frame_valid_q, err_width_q, err_count_q, err_timeout_q;
  logic        rise, fall, timeout_hit;
  pulse_e      pulse_class;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  // Window bounds are formed at 17 bits so neither N-TOL nor N+TOL wraps.
  function automatic logic in_window(input logic [15:0] cnt, input logic [15:0] nom);
    logic [16:0] lo_b;
    logic [16:0] hi_b;
    lo_b = (nom >= TOL) ? {1'b0, nom - TOL} : 17'd0;
    hi_b = {1'b0, nom} + {1'b0, TOL};
    if (hi_b > 17'h0FFFF) hi_b = 17'h0FFFF;
    return ({1'b0, cnt} >= lo_b) && ({1'b0, cnt} <= hi_b);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    hi_cnt_d = hi_cnt_q;
    lo_cnt_d = lo_cnt_q;
    if (rise)                           hi_cnt_d = 16'd1;
    else if (s2_q && hi_cnt_q != 16'hFFFF) hi_cnt_d = hi_cnt_q + 16'd1;
    if (fall)                            lo_cnt_d = 16'd1;
    else if (!s2_q && lo_cnt_q != 16'hFFFF) lo_cnt_d = lo_cnt_q + 16'd1;

    pulse_class = P_BAD;
    if      (in_window(hi_cnt_q, ON_imp))  pulse_class = P_IMP;
    else if (in_window(hi_cnt_q, ON_stop)) pulse_class = P_STOP;
    else if (in_window(hi_cnt_q, ON_high)) pulse_class = P_HIGH;
    else if (in_window(hi_cnt_q, ON_low))  pulse_class = P_LOW;

    timeout_hit = (state_q == S_DATA) && (bit_cnt_q != 3'd0) && !s2_q &&
                  ({1'b0, lo_cnt_d} == ({1'b0, GAP_MAX} + 17'd1));
  end

  always_ff @(posedge clk_out) begin
    if (reset) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      hi_cnt_q      <= '0;
      lo_cnt_q      <= '0;
      state_q       <= S_HUNT;
      bit_cnt_q     <= '0;
      data_q        <= '0;
      tele_q        <= '0;
      frame_count_q <= '0;
      frame_valid_q <= 1'b0;
      err_width_q   <= 1'b0;
      err_count_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
      s1_q          <= pulse_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      hi_cnt_q      <= hi_cnt_d;
      lo_cnt_q      <= lo_cnt_d;
      frame_valid_q <= 1'b0;
      err_width_q   <= 1'b0;
      err_count_q   <= 1'b0;
      err_timeout_q <= 1'b0;

      if (fall) begin
        if (state_q == S_HUNT) begin
          if (pulse_class == P_IMP || pulse_class == P_STOP) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
          end
        end else begin
          case (pulse_class)
            P_IMP: bit_cnt_q <= '0;
            P_STOP: begin
              bit_cnt_q <= '0;
              if (bit_cnt_q == 3'd6 || bit_cnt_q == 3'd5) begin
                // Five-bit frames carry a,b,c,d,f: f sits in slot 4 and e reads as 0.
                tele_q        <= (bit_cnt_q == 3'd6) ? {2'b00, data_q}
                                                     : {2'b01, data_q[4], 1'b0, data_q[3:0]};
                frame_valid_q <= 1'b1;
                frame_count_q <= frame_count_q + 8'd1;
              end else begin
                err_count_q <= 1'b1;
              end
            end
            P_HIGH, P_LOW: begin
              if (bit_cnt_q == 3'd6) begin
                err_count_q <= 1'b1;
                state_q     <= S_HUNT;
                bit_cnt_q   <= '0;
              end else begin
                data_q[bit_cnt_q] <= (pulse_class == P_HIGH);
                bit_cnt_q         <= bit_cnt_q + 3'd1;
              end
            end
            default: begin
              err_width_q <= 1'b1;
              state_q     <= S_HUNT;
              bit_cnt_q   <= '0;
            end
          endcase
        end
      end else if (timeout_hit) begin
        err_timeout_q <= 1'b1;
        state_q       <= S_HUNT;
        bit_cnt_q     <= '0;
      end
    end
  end

  assign tele        = tele_q;
  assign frame_valid = frame_valid_q;
  assign frame_count = frame_count_q;
  assign err_width   = err_width_q;
  assign err_count   = err_count_q;
  assign err_timeout = err_timeout_q;
  assign locked      = (state_q == S_DATA);

endmodule

// File: tb/tb_tele_pulse_decoder.sv
// Directed bench for tele_pulse_decoder: a pulse table with hand-computed
// results, then timeout, frame-count wrap and mid-frame reset sequences.
module tb_tele_pulse_decoder;

  logic        clk_out = 1'b0;
  logic        reset;
  logic        pulse_in;
  logic [15:0] ON_imp, ON_low, ON_high, ON_stop;
  logic [7:0]  tele, frame_count;
  logic        frame_valid, err_width, err_count, err_timeout, locked;

  tele_pulse_decoder #(.TOL(16'd10), .GAP_MAX(16'd300)) dut (
    .clk_out    (clk_out),
    .reset      (reset),
    .pulse_in   (pulse_in),
    .ON_imp     (ON_imp),
    .ON_low     (ON_low),
    .ON_high    (ON_high),
    .ON_stop    (ON_stop),
    .tele       (tele),
    .frame_valid(frame_valid),
    .frame_count(frame_count),
    .err_width  (err_width),
    .err_count  (err_count),
    .err_timeout(err_timeout),
    .locked     (locked)
  );

  always #5 clk_out = ~clk_out;

  // Strobe vector layout: {frame_valid, err_width, err_count, err_timeout}
  localparam logic [3:0] FV = 4'b1000, EW = 4'b0100, EC = 4'b0010, ET = 4'b0001, NO = 4'b0000;

  typedef struct {
    int unsigned width;
    logic [3:0]  strb;
    logic        lock;
    logic [7:0]  tele;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   et_seen  = 0;
  int   any_seen = 0;
  logic [3:0] got_early, got_main, got_post;

  always @(negedge clk_out) begin
    if (!reset) begin
      if (err_timeout) et_seen++;
      if (frame_valid | err_width | err_count | err_timeout) any_seen++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic add(input int unsigned w, input logic [3:0] s, input logic l,
                     input logic [7:0] t, input logic [7:0] c);
    vec_t v;
    v.width = w; v.strb = s; v.lock = l; v.tele = t; v.cnt = c;
    vecs.push_back(v);
  endtask

  // Strobes for a fall belong at the third negedge after the line drops (edge N+2).
  task automatic send_pulse(input int w, input int gap);
    pulse_in = 1'b1;
    repeat (w) @(negedge clk_out);
    pulse_in = 1'b0;
    repeat (2) @(negedge clk_out);
    got_early = {frame_valid, err_width, err_count, err_timeout};
    @(negedge clk_out);
    got_main = {frame_valid, err_width, err_count, err_timeout};
    @(negedge clk_out);
    got_post = {frame_valid, err_width, err_count, err_timeout};
    repeat (gap - 4) @(negedge clk_out);
  endtask

  initial begin
    int first_to;
    int to_cnt;
    logic lock_at;
    int snap;
    logic [7:0] exp_cnt;

    reset = 1'b1; pulse_in = 1'b0;
    ON_imp = 16'd400; ON_low = 16'd100; ON_high = 16'd200; ON_stop = 16'd600;
    repeat (3) @(negedge clk_out);
    check("reset_outputs", {tele, frame_valid, frame_count, err_width, err_count, err_timeout, locked}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk_out);

    add(200, NO, 0, 8'h00, 0);                       // stray bit in HUNT is ignored
    add(400, NO, 1, 8'h00, 0);
    add(200, NO, 1, 8'h00, 0); add(100, NO, 1, 8'h00, 0); add(200, NO, 1, 8'h00, 0);
    add(200, NO, 1, 8'h00, 0); add(100, NO, 1, 8'h00, 0); add(200, NO, 1, 8'h00, 0);
    add(600, FV, 1, 8'h2D, 1);
    add(200, NO, 1, 8'h2D, 1); add(200, NO, 1, 8'h2D, 1); add(100, NO, 1, 8'h2D, 1);
    add(200, NO, 1, 8'h2D, 1); add(100, NO, 1, 8'h2D, 1);
    add(600, FV, 1, 8'h4B, 2);                       // five-bit NFC-bypass frame
    add(210, NO, 1, 8'h4B, 2); add(190, NO, 1, 8'h4B, 2);
    add(211, EW, 0, 8'h4B, 2);
    add(600, NO, 1, 8'h4B, 2);
    add(189, EW, 0, 8'h4B, 2);
    add(390, NO, 1, 8'h4B, 2);                       // lowest accepted IMP locks
    add(100, NO, 1, 8'h4B, 2); add(200, NO, 1, 8'h4B, 2);
    add(100, NO, 1, 8'h4B, 2); add(200, NO, 1, 8'h4B, 2);
    add(600, EC, 1, 8'h4B, 2);
    add(100, NO, 1, 8'h4B, 2); add(200, NO, 1, 8'h4B, 2); add(200, NO, 1, 8'h4B, 2);
    add(100, NO, 1, 8'h4B, 2); add(100, NO, 1, 8'h4B, 2); add(200, NO, 1, 8'h4B, 2);
    add(600, FV, 1, 8'h26, 3);
    add(200, NO, 1, 8'h26, 3); add(200, NO, 1, 8'h26, 3);
    add(400, NO, 1, 8'h26, 3);                       // IMP inside a frame restarts it
    for (int i = 0; i < 6; i++) add(200, NO, 1, 8'h26, 3);
    add(600, FV, 1, 8'h3F, 4);
    for (int i = 0; i < 6; i++) add(100, NO, 1, 8'h3F, 4);
    add(100, EC, 0, 8'h3F, 4);                       // seventh bit
    add(600, NO, 1, 8'h3F, 4);

    for (int i = 0; i < vecs.size(); i++) begin
      send_pulse(int'(vecs[i].width), 100);
      check($sformatf("row%0d strobes", i), {got_early, got_main, got_post}, {4'b0, vecs[i].strb, 4'b0});
      check($sformatf("row%0d locked", i), locked, vecs[i].lock);
      check($sformatf("row%0d tele", i), tele, vecs[i].tele);
      check($sformatf("row%0d count", i), frame_count, vecs[i].cnt);
    end

    // In-frame gap timeout: IMP, three bits, then the line stays low.
    send_pulse(400, 100);
    send_pulse(200, 100);
    send_pulse(100, 100);
    pulse_in = 1'b1;
    repeat (200) @(negedge clk_out);
    pulse_in = 1'b0;
    first_to = 0; to_cnt = 0; lock_at = 1'b1;
    for (int k = 1; k <= 305; k++) begin
      @(negedge clk_out);
      if (err_timeout) begin
        to_cnt++;
        if (first_to == 0) first_to = k;
      end
      if (k == 303) lock_at = locked;
    end
    check("timeout_cycle", first_to, 303);
    check("timeout_pulses", to_cnt, 1);
    check("timeout_unlock", lock_at, 1'b0);
    send_pulse(200, 100);
    check("after_timeout_bit", {got_main, locked}, {NO, 1'b0});
    send_pulse(600, 100);
    check("relock_after_timeout", {got_main, locked}, {NO, 1'b1});
    snap = et_seen;
    repeat (400) @(negedge clk_out);
    check("idle_no_timeout", et_seen - snap, 0);
    check("idle_locked", locked, 1'b1);

    // Short widths so 256 frames stay cheap; windows do not overlap at TOL=10.
    ON_low = 16'd12; ON_high = 16'd33; ON_imp = 16'd54; ON_stop = 16'd75;
    exp_cnt = 8'd4;
    for (int f = 0; f < 256; f++) begin
      for (int b = 0; b < 5; b++) send_pulse(12, 5);
      send_pulse(75, 5);
      exp_cnt = exp_cnt + 8'd1;
      check($sformatf("wrap_frame%0d", f), got_main, FV);
      if (exp_cnt == 8'd0) check("count_wraps_to_0", frame_count, 0);
    end
    check("count_after_256", frame_count, 8'd4);
    check("tele_after_256", tele, 8'h40);

    // Reset in the middle of the fourth bit.
    for (int b = 0; b < 3; b++) send_pulse(33, 5);
    pulse_in = 1'b1;
    repeat (10) @(negedge clk_out);
    reset = 1'b1;
    @(negedge clk_out);
    check("midframe_reset", {tele, frame_valid, frame_count, err_width, err_count, err_timeout, locked}, 0);
    reset = 1'b0;
    snap = any_seen;
    repeat (20) @(negedge clk_out);
    pulse_in = 1'b0;
    repeat (10) @(negedge clk_out);
    send_pulse(33, 5);
    send_pulse(12, 5);
    check("hunt_after_reset_strobes", any_seen - snap, 0);
    check("hunt_after_reset_locked", locked, 1'b0);
    send_pulse(75, 5);
    check("resync_after_reset", {got_main, locked}, {NO, 1'b1});
    send_pulse(33, 5); send_pulse(12, 5); send_pulse(12, 5);
    send_pulse(12, 5); send_pulse(12, 5); send_pulse(33, 5);
    send_pulse(75, 5);
    check("post_reset_frame_strobe", got_main, FV);
    check("post_reset_tele", tele, 8'h21);
    check("post_reset_count", frame_count, 8'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tele_pulse_decoder.md
Name: tele_pulse_decoder

Overview:
Receive-side counterpart of the door-handle telegram pulse generator. Measures the high-time of each pulse on pulse_in in clk_out cycles and classifies it as start impulse, stop, logic-1 or logic-0 against the ON_* nominal widths. Reassembles the 7-bit telegram, including the NFC-bypass form in which bit e is omitted, and reports each completed frame with a one-cycle strobe. Sits on the HIL bench input that loops back or monitors the handle line.

Parameters:
TOL, 16'd50, symmetric acceptance tolerance in cycles applied to every nominal width.
GAP_MAX, 16'd4000, maximum low-time between pulses inside a frame before timeout.

Ports:
clk_out  in  1  system clock; all flops on the rising edge.
reset  in  1  synchronous, active-high reset.
pulse_in  in  1  asynchronous telegram line, active high.
ON_imp  in  16  nominal start-impulse high-time, in cycles.
ON_low  in  16  nominal logic-0 high-time.
ON_high  in  16  nominal logic-1 high-time.
ON_stop  in  16  nominal stop-pulse high-time.
tele  out  8  last good telegram: [5:0] = f,e,d,c,b,a; [6] = g; [7] = 0.
frame_valid  out  1  one-cycle strobe; tele updated in the same cycle.
frame_count  out  8  count of good frames, mod 256.
err_width  out  1  one-cycle strobe: high-time matched no window.
err_count  out  1  one-cycle strobe: stop received after a bit count other than 5 or 6.
err_timeout  out  1  one-cycle strobe: in-frame gap exceeded GAP_MAX.
locked  out  1  high while in DATA state.

Behaviour:
- Reset: all outputs 0, state HUNT, counters and shift register cleared. Reset dominates every other event in the same cycle.
- Input path: 2-flop synchroniser s1, s2, plus a history flop s3. Rise = s2 & ~s3. Fall = ~s2 & s3.
- hi_cnt: cleared on rise, increments while s2 = 1, saturates at 16'hFFFF. It holds the exact high-time in cycles when fall is detected.
- lo_cnt: cleared on fall, increments while s2 = 0, saturates at 16'hFFFF.
- Window test for nominal N: hi_cnt >= max(N-TOL, 0) and hi_cnt <= min(N+TOL, 16'hFFFF). Compute at 17 bits so nothing wraps.
- Classification priority when windows overlap: IMP > STOP > HIGH > LOW. No match = BAD.
- States:
  - HUNT: on fall classified IMP or STOP, go to DATA with bit_cnt = 0. Any other pulse is ignored, with no error.
  - DATA, on fall classified HIGH or LOW:
    - If bit_cnt < 6: shift the bit into position bit_cnt (a first), then bit_cnt++.
    - If bit_cnt = 6: raise err_count and go to HUNT.
  - DATA, on fall classified STOP:
    - bit_cnt = 6: tele = {0, 0, f, e, d, c, b, a}.
    - bit_cnt = 5: received bits are a, b, c, d, f. tele = {0, 1, f, 0, d, c, b, a}.
    - In both cases: pulse frame_valid, frame_count++ (wraps 255 -> 0), stay in DATA, bit_cnt = 0. The stop pulse resynchronises the next frame.
    - Any other bit_cnt: pulse err_count, clear bit_cnt, stay in DATA.
  - DATA, on fall classified IMP: restart with bit_cnt = 0 and no error.
  - DATA, on fall classified BAD: pulse err_width, go to HUNT.
  - DATA with bit_cnt > 0 and lo_cnt reaching GAP_MAX+1: pulse err_timeout, go to HUNT. Idle with bit_cnt = 0 never times out.
- Latency: let N be the first clock edge that samples pulse_in low. Fall is detected in cycle N+1. frame_valid and the err_* strobes are registered at edge N+2 and are high for exactly one cycle.
- tele holds its value between frames and is never altered by errors.
- Strobes are mutually exclusive; at most one pulse per fall event.

Test Plan:
Common setup: ON_imp=400, ON_low=100, ON_high=200, ON_stop=600, TOL=10, GAP_MAX=300, 100-cycle gaps.
1. Reset, then IMP, bits a..f = 1,0,1,1,0,1, then STOP -> one frame_valid, tele=8'h2D, frame_count=1, no err_*. Check frame_valid at edge N+2.
2. Five-bit frame a,b,c,d,f = 1,1,0,1,0, then STOP (generator Tele=8'h5B with g=1) -> tele=8'h4B, frame_count increments.
3. Tolerance edges: a logic-1 pulse of 210 and one of 190 are accepted. A logic-1 pulse of 211 -> err_width, locked=0; the following STOP re-locks with no frame_valid.
4. Four bits then STOP -> err_count, locked stays 1. The next full 6-bit frame plus STOP decodes correctly.
5. IMP, three bits, then line low for 301 cycles -> err_timeout at the 301st low cycle, locked=0. Subsequent bits are ignored until IMP or STOP.
6. 256 back-to-back STOP-delimited frames -> frame_count wraps to 0. Reset asserted mid-frame at bit 3 -> all outputs 0 the next cycle, and decoding resumes only after a sync pulse.
